// File: rtl/t_using_sr_counter.sv
// WIDTH-bit counter / toggle bank built from SR storage cells driven by T-to-SR excitation.
// Each cell records a sticky error if S and R are ever both high on a clock edge.

module t_sr_cell (
    input  logic clk,
    input  logic i_res,
    input  logic i_s,
    input  logic i_r,
    output logic o_q,
    output logic o_err
);

    logic r_q;
    logic r_err;

    // SR storage: S=R=1 holds state and latches the error flag
    always_ff @(posedge clk) begin
        if (i_res) begin
            r_q   <= 1'b0;
            r_err <= 1'b0;
        end else begin
            case ({i_s, i_r})
                2'b10:   r_q <= 1'b1;
                2'b01:   r_q <= 1'b0;
                default: r_q <= r_q;
            endcase
            if (i_s && i_r) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_q   = r_q;
    assign o_err = r_err;

endmodule

module t_using_sr_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             tmode,
    input  logic [WIDTH-1:0] tmask,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             sr_err
);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_all_up;
    logic [WIDTH-1:0] w_all_dn;
    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_r;
    logic [WIDTH-1:0] w_cell_err;

    // Prefix AND of lower bits: all-ones below i for up, all-zeros below i for down
    always_comb begin
        logic v_run_up;
        logic v_run_dn;
        w_all_up = '0;
        w_all_dn = '0;
        v_run_up = 1'b1;
        v_run_dn = 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_all_up[i] = v_run_up;
            w_all_dn[i] = v_run_dn;
            v_run_up    = v_run_up & w_q[i];
            v_run_dn    = v_run_dn & ~w_q[i];
        end
    end

    // T selection by priority: load > tmode > count enable > hold
    always_comb begin
        w_t = '0;
        if (load) begin
            w_t = '0;
        end else if (tmode) begin
            w_t = tmask;
        end else if (en) begin
            w_t = up ? w_all_up : w_all_dn;
        end
    end

    // Excitation: load drives cells straight to d, otherwise T-to-SR conversion
    always_comb begin
        w_s = w_t & ~w_q;
        w_r = w_t & w_q;
        if (load) begin
            w_s = d & ~w_q;
            w_r = ~d & w_q;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        t_sr_cell u_cell (
            .clk   (clk),
            .i_res (res),
            .i_s   (w_s[g]),
            .i_r   (w_r[g]),
            .o_q   (w_q[g]),
            .o_err (w_cell_err[g])
        );
    end

    assign q      = w_q;
    assign sr_err = |w_cell_err;
    assign tc     = en & ~load & ~tmode & ((up & (&w_q)) | (~up & ~(|w_q)));

endmodule
